// File: rtl/control_pipe_if.sv
// Handshake/control bundle between the IF/ID register, the control pipe and the datapath.
// The master drives opcode/valid/stall/flush; the slave (control_pipe) returns the staged controls.
interface control_pipe_if #(
  parameter int ALUOP_W = 5,
  parameter int CNT_W   = 16
);
  logic [5:0]         i_control_pipe_opcode;
  logic               i_control_pipe_valid;
  logic               i_control_pipe_stall;
  logic               i_control_pipe_flush;
  logic               o_control_pipe_regdst;
  logic               o_control_pipe_alusrc;
  logic [ALUOP_W-1:0] o_control_pipe_aluop;
  logic               o_control_pipe_jump;
  logic               o_control_pipe_link;
  logic               o_control_pipe_memread;
  logic               o_control_pipe_memwrite;
  logic               o_control_pipe_branch;
  logic               o_control_pipe_branchne;
  logic               o_control_pipe_regwrite;
  logic               o_control_pipe_memtoreg;
  logic               o_control_pipe_illegal;
  logic [CNT_W-1:0]   o_control_pipe_bubbles;

  modport master (
    output i_control_pipe_opcode, i_control_pipe_valid, i_control_pipe_stall, i_control_pipe_flush,
    input  o_control_pipe_regdst, o_control_pipe_alusrc, o_control_pipe_aluop, o_control_pipe_jump,
    input  o_control_pipe_link, o_control_pipe_memread, o_control_pipe_memwrite, o_control_pipe_branch,
    input  o_control_pipe_branchne, o_control_pipe_regwrite, o_control_pipe_memtoreg,
    input  o_control_pipe_illegal, o_control_pipe_bubbles
  );

  modport slave (
    input  i_control_pipe_opcode, i_control_pipe_valid, i_control_pipe_stall, i_control_pipe_flush,
    output o_control_pipe_regdst, o_control_pipe_alusrc, o_control_pipe_aluop, o_control_pipe_jump,
    output o_control_pipe_link, o_control_pipe_memread, o_control_pipe_memwrite, o_control_pipe_branch,
    output o_control_pipe_branchne, o_control_pipe_regwrite, o_control_pipe_memtoreg,
    output o_control_pipe_illegal, o_control_pipe_bubbles
  );
endinterface

// File: rtl/control_pipe.sv
// Pipelined MIPS main control: decodes the opcode in ID and walks the EX/MEM/WB control
// groups through ID/EX, EX/MEM and MEM/WB, with stall bubbles, flush, illegal flag and bubble count.
module control_pipe #(
  parameter int ALUOP_W = 5,
  parameter int JUMP_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic          i_control_pipe_clk,
  input  logic          i_control_pipe_rst,
  control_pipe_if.slave bus
);

  typedef struct packed {
    logic               regdst;
    logic               alusrc;
    logic [ALUOP_W-1:0] aluop;
    logic               jump;
    logic               link;
  } ex_t;

  typedef struct packed {
    logic memread;
    logic memwrite;
    logic branch;
    logic branchne;
  } mem_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } wb_t;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_LUI   = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] ALU_RTYPE = ALUOP_W'(31);
  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

  ex_t  w_dec_ex;
  mem_t w_dec_mem;
  wb_t  w_dec_wb;
  logic w_dec_illegal;
  logic w_advance;

  ex_t              r_idex_ex;
  mem_t             r_idex_mem;
  wb_t              r_idex_wb;
  logic             r_idex_valid;
  mem_t             r_exmem_mem;
  wb_t              r_exmem_wb;
  logic             r_exmem_valid;
  wb_t              r_memwb_wb;
  logic             r_memwb_valid;
  logic             r_illegal;
  logic [CNT_W-1:0] r_bubbles;

  always_comb begin
    w_dec_ex      = '0;
    w_dec_mem     = '0;
    w_dec_wb      = '0;
    w_dec_illegal = 1'b0;
    if (bus.i_control_pipe_valid) begin
      case (bus.i_control_pipe_opcode)
        6'h00: begin w_dec_ex.regdst = 1'b1; w_dec_ex.aluop = ALU_RTYPE; w_dec_wb.regwrite = 1'b1; end
        6'h23: begin
          w_dec_ex.alusrc = 1'b1; w_dec_ex.aluop = ALU_ADD; w_dec_mem.memread = 1'b1;
          w_dec_wb.regwrite = 1'b1; w_dec_wb.memtoreg = 1'b1;
        end
        6'h2B: begin w_dec_ex.alusrc = 1'b1; w_dec_ex.aluop = ALU_ADD; w_dec_mem.memwrite = 1'b1; end
        6'h04: begin w_dec_ex.aluop = ALU_SUB; w_dec_mem.branch = 1'b1; end
        6'h05: begin w_dec_ex.aluop = ALU_SUB; w_dec_mem.branchne = 1'b1; end
        6'h08: begin w_dec_ex.alusrc = 1'b1; w_dec_ex.aluop = ALU_ADD; w_dec_wb.regwrite = 1'b1; end
        6'h0C: begin w_dec_ex.alusrc = 1'b1; w_dec_ex.aluop = ALU_AND; w_dec_wb.regwrite = 1'b1; end
        6'h0D: begin w_dec_ex.alusrc = 1'b1; w_dec_ex.aluop = ALU_OR;  w_dec_wb.regwrite = 1'b1; end
        6'h0A: begin w_dec_ex.alusrc = 1'b1; w_dec_ex.aluop = ALU_SLT; w_dec_wb.regwrite = 1'b1; end
        6'h0F: begin w_dec_ex.alusrc = 1'b1; w_dec_ex.aluop = ALU_LUI; w_dec_wb.regwrite = 1'b1; end
        6'h02: begin
          if (JUMP_EN != 0) w_dec_ex.jump = 1'b1;
          else              w_dec_illegal = 1'b1;
        end
        6'h03: begin
          if (JUMP_EN != 0) begin
            w_dec_ex.jump = 1'b1; w_dec_ex.link = 1'b1; w_dec_wb.regwrite = 1'b1;
          end else begin
            w_dec_illegal = 1'b1;
          end
        end
        default: w_dec_illegal = 1'b1;
      endcase
    end
  end

  // Only an instruction that actually enters ID/EX may count as illegal; flush overrides stall.
  assign w_advance = !bus.i_control_pipe_stall && !bus.i_control_pipe_flush;

  always_ff @(posedge i_control_pipe_clk or posedge i_control_pipe_rst) begin
    if (i_control_pipe_rst) begin
      r_idex_ex     <= '0;
      r_idex_mem    <= '0;
      r_idex_wb     <= '0;
      r_idex_valid  <= 1'b0;
      r_exmem_mem   <= '0;
      r_exmem_wb    <= '0;
      r_exmem_valid <= 1'b0;
      r_memwb_wb    <= '0;
      r_memwb_valid <= 1'b0;
      r_illegal     <= 1'b0;
      r_bubbles     <= '0;
    end else begin
      if (w_advance) begin
        r_idex_ex    <= w_dec_ex;
        r_idex_mem   <= w_dec_mem;
        r_idex_wb    <= w_dec_wb;
        r_idex_valid <= bus.i_control_pipe_valid && !w_dec_illegal;
      end else begin
        r_idex_ex    <= '0;
        r_idex_mem   <= '0;
        r_idex_wb    <= '0;
        r_idex_valid <= 1'b0;
      end

      if (bus.i_control_pipe_flush) begin
        r_exmem_mem   <= '0;
        r_exmem_wb    <= '0;
        r_exmem_valid <= 1'b0;
      end else begin
        r_exmem_mem   <= r_idex_mem;
        r_exmem_wb    <= r_idex_wb;
        r_exmem_valid <= r_idex_valid;
      end

      r_memwb_wb    <= r_exmem_wb;
      r_memwb_valid <= r_exmem_valid;

      if (w_advance && w_dec_illegal)
        r_illegal <= 1'b1;

      if (bus.i_control_pipe_stall && !bus.i_control_pipe_flush && r_bubbles != CNT_MAX)
        r_bubbles <= r_bubbles + CNT_W'(1);
    end
  end

  assign bus.o_control_pipe_regdst   = r_idex_ex.regdst  & r_idex_valid;
  assign bus.o_control_pipe_alusrc   = r_idex_ex.alusrc  & r_idex_valid;
  assign bus.o_control_pipe_aluop    = r_idex_ex.aluop   & {ALUOP_W{r_idex_valid}};
  assign bus.o_control_pipe_jump     = r_idex_ex.jump    & r_idex_valid;
  assign bus.o_control_pipe_link     = r_idex_ex.link    & r_idex_valid;
  assign bus.o_control_pipe_memread  = r_exmem_mem.memread  & r_exmem_valid;
  assign bus.o_control_pipe_memwrite = r_exmem_mem.memwrite & r_exmem_valid;
  assign bus.o_control_pipe_branch   = r_exmem_mem.branch   & r_exmem_valid;
  assign bus.o_control_pipe_branchne = r_exmem_mem.branchne & r_exmem_valid;
  assign bus.o_control_pipe_regwrite = r_memwb_wb.regwrite & r_memwb_valid;
  assign bus.o_control_pipe_memtoreg = r_memwb_wb.memtoreg & r_memwb_valid;
  assign bus.o_control_pipe_illegal  = r_illegal;
  assign bus.o_control_pipe_bubbles  = r_bubbles;

endmodule

// File: doc/control_pipe.md
Name: control_pipe

Overview:
- Parametrised successor to the single-cycle MIPS main control decoder.
- Decodes the 6-bit opcode in ID and carries the EX, MEM and WB control groups through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Adds load-use stall bubbles, branch flush, jump support, an illegal-opcode flag and a bubble counter.
- Sits between the IF/ID register and the datapath stage registers of the 5-stage pipeline.

Parameters:
- ALUOP_W, 5: width of the ALU operation code (must be ≥5); encodings are zero-extended to this width.
- JUMP_EN, 1: 1 decodes j/jal; 0 treats opcodes 0x02/0x03 as illegal.
- CNT_W, 16: width of the bubble counter.

Ports:
- i_control_pipe_clk  in  1  clock, rising edge.
- i_control_pipe_rst  in  1  asynchronous, active-high reset.
- i_control_pipe_opcode  in  6  instruction[31:26] from IF/ID.
- i_control_pipe_valid  in  1  IF/ID holds a real instruction.
- i_control_pipe_stall  in  1  load-use hazard; insert bubble into ID/EX.
- i_control_pipe_flush  in  1  branch/jump taken; kill ID/EX and EX/MEM contents.
- o_control_pipe_regdst  out  1  EX group, ID/EX stage.
- o_control_pipe_alusrc  out  1  EX group, ID/EX stage.
- o_control_pipe_aluop  out  ALUOP_W  EX group, ID/EX stage.
- o_control_pipe_jump  out  1  EX group, ID/EX stage.
- o_control_pipe_link  out  1  EX group, ID/EX stage (jal writes $31).
- o_control_pipe_memread  out  1  MEM group, EX/MEM stage.
- o_control_pipe_memwrite  out  1  MEM group, EX/MEM stage.
- o_control_pipe_branch  out  1  MEM group, EX/MEM stage (beq).
- o_control_pipe_branchne  out  1  MEM group, EX/MEM stage (bne).
- o_control_pipe_regwrite  out  1  WB group, MEM/WB stage.
- o_control_pipe_memtoreg  out  1  WB group, MEM/WB stage.
- o_control_pipe_illegal  out  1  sticky illegal-opcode flag.
- o_control_pipe_bubbles  out  CNT_W  count of inserted stall bubbles.

Behaviour:
- Reset (asynchronous, active-high): every output and all internal stage registers are 0, including valid bits, the flag and the counter. Reset asserted mid-operation clears everything immediately, with no clock edge required.
- Decode is combinational on opcode and is gated by valid. An invalid slot decodes to all-zero controls.
- ALU op encodings: ADD=0, SUB=1, AND=2, OR=3, SLT=4, LUI=5, RTYPE=31 (funct is decoded downstream).
- Decode table (signals not listed are 0):
  - 0x00 R-type: regdst=1, regwrite=1, aluop=RTYPE.
  - 0x23 lw: alusrc=1, memread=1, memtoreg=1, regwrite=1, aluop=ADD.
  - 0x2B sw: alusrc=1, memwrite=1, aluop=ADD.
  - 0x04 beq: branch=1, aluop=SUB.
  - 0x05 bne: branchne=1, aluop=SUB.
  - 0x08 addi: alusrc=1, regwrite=1, aluop=ADD.
  - 0x0C andi: alusrc=1, regwrite=1, aluop=AND.
  - 0x0D ori: alusrc=1, regwrite=1, aluop=OR.
  - 0x0A slti: alusrc=1, regwrite=1, aluop=SLT.
  - 0x0F lui: alusrc=1, regwrite=1, aluop=LUI.
  - 0x02 j: jump=1.
  - 0x03 jal: jump=1, link=1, regwrite=1.
  - Any other opcode: all zero; with valid=1, sets illegal, which holds until reset.
- Latency from the sampling edge: EX outputs after 1 edge, MEM outputs after 2 edges, WB outputs after 3 edges. Each group moves one stage per edge, unconditionally, with its valid bit.
- Stall=1: ID/EX loads all-zero (bubble) and the bubble counter increments. The counter saturates at all-ones and does not wrap. The IF/ID slot is held upstream, so the same opcode is re-decoded next cycle. EX/MEM and MEM/WB advance normally.
- Flush=1: ID/EX and EX/MEM load zero on that edge; MEM/WB advances normally, so an older instruction in MEM still writes back.
- Flush and stall together: flush wins. The counter does not increment and illegal is not set for the killed opcode.
- An illegal opcode under stall or flush does not set the flag. An illegal opcode that is valid with neither stall nor flush sets the flag on the edge it is sampled.

Test Plan:
- Reset then idle: assert rst asynchronously mid-cycle -> all outputs 0 immediately; bubbles=0, illegal=0.
- Stream lw, sw, R-type, beq with valid=1 -> cycle 1 alusrc=1, aluop=0; cycle 2 memread=1; cycle 3 regwrite=1 and memtoreg=1. Later groups follow in order with exact 1/2/3-edge latency.
- lw followed by a 2-cycle stall on an add -> two zero ID/EX slots, bubbles=2; the add's EX group appears on the 3rd edge.
- jal with JUMP_EN=1 -> jump=1, link=1, then regwrite=1 three edges after sampling. Same input with JUMP_EN=0 -> all zero and illegal=1.
- Flush while beq is in EX and addi is in ID -> next edge EX and MEM outputs are 0. Stall and flush together -> bubbles unchanged.
- CNT_W=2: hold stall for 5 cycles -> bubbles saturates at 3. Opcode 0x3F with valid=0 -> illegal stays 0; with valid=1 -> illegal=1, held until reset.
